// File: rtl/wb_uart_fifo.sv
// wb_uart_fifo - Wishbone B4 pipelined slave UART with TX/RX FIFOs, a runtime
// baud divider and sticky error flags.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i        bus request (accepted when both high)
//   wb_we_i, wb_adr_i[1:0]    write enable, register select
//   wb_dat_i[31:0]            write data
//   wb_dat_o[31:0]            read data, valid with wb_ack_o
//   wb_stall_o                tied low
//   wb_ack_o                  one pulse, one cycle after each accepted request
//   uart_rx                   asynchronous serial input, idle high
//   uart_tx                   serial output, idle high
//
// Registers
//   0 DATA     W: push to TX FIFO   R: pop RX FIFO (0 when empty)
//   1 STATUS   R: {rx_perr, frm_err, rx_ovf, tx_ovf, tx_busy, tx_full, rx_empty};
//              a read clears bits 6..3
//   2 DIVIDER  R/W, 16-bit clocks per bit, clamped to >= 2, applied per frame
//   3          reads 0
//
// Build option: define WB_UART_PARITY_EN to add an even-parity bit to every
// frame (generated on TX, checked on RX into rx_perr).
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, waiting for TX FIFO data
//   TX_START  | start bit (low)
//   TX_DATA   | DATA_BITS payload bits, LSB first
//   TX_PARITY | even-parity bit (parity build only)
//   TX_STOP   | stop bit (high); chains straight to TX_START if data queued
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for a falling edge on the synchronised line
//   RX_START  | half-bit wait, then confirm start bit still low
//   RX_DATA   | sample payload bits mid-bit
//   RX_PARITY | sample parity bit (parity build only)
//   RX_STOP   | sample stop bit, push byte or flag framing error

module wb_uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

module wb_uart_fifo #(
  parameter int TICKS_PER_BAUD = 3,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_DIV    = 2'd2;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 req, bus_wr, bus_rd, stat_rd;
  logic [15:0]          div;
  logic                 tx_ovf, rx_ovf, frm_err, rx_perr;
  logic [6:0]           status;
  logic                 unused_bits;

  logic                 txf_push, txf_pop, txf_empty, txf_full;
  logic [DATA_BITS-1:0] txf_dout;
  logic                 rxf_push, rxf_pop, rxf_empty, rxf_full;
  logic [DATA_BITS-1:0] rxf_dout;

  logic [2:0]           tx_state, tx_bit;
  logic [15:0]          tx_cnt, tx_div;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_line, tx_load, tx_busy;

  logic [2:0]           rx_state, rx_bit;
  logic [15:0]          rx_cnt, rx_div;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_s1, rx_s2, rx_d;
  logic                 rx_stop_smp, rx_frm_set, rx_perr_set;
`ifdef WB_UART_PARITY_EN
  logic                 rx_par_bad;
`endif

  assign wb_stall_o  = 1'b0;
  assign unused_bits = ^wb_dat_i[31:16];

  assign req      = wb_cyc_i & wb_stb_i;
  assign bus_wr   = req & wb_we_i;
  assign bus_rd   = req & ~wb_we_i;
  assign stat_rd  = bus_rd & (wb_adr_i == ADR_STATUS);
  assign txf_push = bus_wr & (wb_adr_i == ADR_DATA);
  assign rxf_pop  = bus_rd & (wb_adr_i == ADR_DATA);

  assign tx_busy = (tx_state != TX_IDLE);
  assign status  = {rx_perr, frm_err, rx_ovf, tx_ovf, tx_busy, txf_full, rxf_empty};

  wb_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(txf_push), .pop(txf_pop),
    .din(wb_dat_i[DATA_BITS-1:0]), .dout(txf_dout), .empty(txf_empty), .full(txf_full)
  );

  wb_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(rxf_push), .pop(rxf_pop),
    .din(rx_sh), .dout(rxf_dout), .empty(rxf_empty), .full(rxf_full)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      div      <= 16'(TICKS_PER_BAUD);
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= '0;
      if (bus_rd) begin
        case (wb_adr_i)
          ADR_DATA:   wb_dat_o <= rxf_empty ? 32'd0 : 32'(rxf_dout);
          ADR_STATUS: wb_dat_o <= {25'd0, status};
          ADR_DIV:    wb_dat_o <= {16'd0, div};
          default:    wb_dat_o <= '0;
        endcase
      end
      if (bus_wr && wb_adr_i == ADR_DIV)
        div <= (wb_dat_i[15:0] < 16'd2) ? 16'd2 : wb_dat_i[15:0];
    end
  end

  // Sticky flags: a new event in the same cycle as a STATUS read survives it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_ovf  <= 1'b0;
      rx_ovf  <= 1'b0;
      frm_err <= 1'b0;
      rx_perr <= 1'b0;
    end else begin
      tx_ovf  <= (tx_ovf  & ~stat_rd) | (txf_push & txf_full & ~txf_pop);
      rx_ovf  <= (rx_ovf  & ~stat_rd) | (rxf_push & rxf_full & ~rxf_pop);
      frm_err <= (frm_err & ~stat_rd) | rx_frm_set;
      rx_perr <= (rx_perr & ~stat_rd) | rx_perr_set;
    end
  end

  // ---------------- transmitter ----------------
  // Divider is captured when a frame is loaded so a DIVIDER write never
  // stretches or shortens a frame already on the wire.
  assign tx_load = ~txf_empty &
                   ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));
  assign txf_pop = tx_load;
  assign uart_tx = tx_line;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else if (tx_load) begin
      tx_state <= TX_START;
      tx_sh    <= txf_dout;
      tx_par   <= ^txf_dout;
      tx_div   <= div;
      tx_cnt   <= div - 16'd1;
      tx_line  <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= tx_div - 16'd1;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            tx_line  <= tx_sh[0];
          end
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
`ifdef WB_UART_PARITY_EN
              tx_state <= TX_PARITY;
              tx_line  <= tx_par;
`else
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
`endif
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              tx_sh   <= tx_sh >> 1;
              tx_line <= tx_sh[1];
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP;
            tx_line  <= 1'b1;
          end
          default: begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rxf_push    = rx_stop_smp & rx_s2;
  assign rx_frm_set  = rx_stop_smp & ~rx_s2;
`ifdef WB_UART_PARITY_EN
  assign rx_perr_set = rxf_push & rx_par_bad;
`else
  assign rx_perr_set = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
`ifdef WB_UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      case (rx_state)
        RX_IDLE: begin
          // First counter expiry lands in the middle of the start bit.
          if (rx_d && !rx_s2) begin
            rx_state <= RX_START;
            rx_div   <= div;
            rx_cnt   <= (div >> 1) - 16'd1;
          end
        end
        default: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_cnt <= rx_div - 16'd1;
            case (rx_state)
              RX_START: begin
                if (rx_s2) rx_state <= RX_IDLE;
                else begin
                  rx_state <= RX_DATA;
                  rx_bit   <= '0;
                end
              end
              RX_DATA: begin
                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                if (rx_bit == LAST_BIT) begin
`ifdef WB_UART_PARITY_EN
                  rx_state <= RX_PARITY;
`else
                  rx_state <= RX_STOP;
`endif
                end else begin
                  rx_bit <= rx_bit + 3'd1;
                end
              end
              RX_PARITY: begin
`ifdef WB_UART_PARITY_EN
                rx_par_bad <= (^rx_sh) ^ rx_s2;
`endif
                rx_state <= RX_STOP;
              end
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule
